// File: rtl/addr8u_check_stage.sv
// addr8u_check_stage: checks an 8-bit unsigned adder result against a
// golden sum, registers it through a 1-deep slot, and logs mismatches.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_a, in_b, in_o    adder operands and the adder's 9-bit result
//   out_valid/out_ready downstream handshake
//   out_sum, out_err    registered sum and mismatch flag
//   err_cnt, err_sticky saturating mismatch count, sticky flag
//   first_a/_b/_o       capture of the first mismatch
//   clr_cnt             clears count, sticky flag and capture
module addr8u_check_stage #(
  parameter bit CORRECT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [8:0]       in_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_sum,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [7:0]       first_a,
  output logic [7:0]       first_b,
  output logic [8:0]       first_o,
  input  logic             clr_cnt
);

  typedef enum logic {
    EMPTY,
    FULL
  } slot_e;

  typedef enum logic {
    CLEAN,
    FAULTED
  } cap_e;

  slot_e slot_q, slot_d;
  cap_e  cap_q, cap_d;

  logic [8:0]       golden;
  logic             mis;
  logic             acc;
  logic [8:0]       sum_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_d;
  logic [7:0]       fa_d;
  logic [7:0]       fb_d;
  logic [8:0]       fo_d;

  assign golden     = {1'b0, in_a} + {1'b0, in_b};
  assign mis        = golden != in_o;
  assign out_valid  = slot_q == FULL;
  assign in_ready   = !out_valid || out_ready;
  assign acc        = in_valid && in_ready;
  assign err_sticky = cap_q == FAULTED;

  // Output slot
  always_comb begin
    slot_d = slot_q;
    sum_d  = out_sum;
    err_d  = out_err;
    unique case (slot_q)
      EMPTY: if (acc) slot_d = FULL;
      FULL: begin
        if (!acc && out_ready)
          slot_d = EMPTY;
      end
      default: slot_d = EMPTY;
    endcase
    if (acc) begin
      sum_d = (CORRECT && mis) ? golden : in_o;
      err_d = mis;
    end
  end

  // Mismatch capture: a clear applies first, so a
  // mismatch in the same cycle lands on clean state.
  always_comb begin
    cnt_base = clr_cnt ? '0 : err_cnt;
    cap_d    = clr_cnt ? CLEAN : cap_q;
    fa_d     = clr_cnt ? 8'h00 : first_a;
    fb_d     = clr_cnt ? 8'h00 : first_b;
    fo_d     = clr_cnt ? 9'h000 : first_o;
    cnt_d    = cnt_base;
    if (acc && mis) begin
      if (cnt_base != '1)
        cnt_d = cnt_base + CNT_W'(1);
      if (cap_d == CLEAN) begin
        cap_d = FAULTED;
        fa_d  = in_a;
        fb_d  = in_b;
        fo_d  = in_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= EMPTY;
      cap_q   <= CLEAN;
      out_sum <= '0;
      out_err <= 1'b0;
      err_cnt <= '0;
      first_a <= '0;
      first_b <= '0;
      first_o <= '0;
    end else begin
      slot_q  <= slot_d;
      cap_q   <= cap_d;
      out_sum <= sum_d;
      out_err <= err_d;
      err_cnt <= cnt_d;
      first_a <= fa_d;
      first_b <= fb_d;
      first_o <= fo_d;
    end
  end

endmodule

// File: tb/tb_addr8u_check_stage.sv
// tb_addr8u_check_stage: directed vectors against two instances
// (CORRECT=1/CNT_W=16 and CORRECT=0/CNT_W=4) with a behavioural model.
module tb_addr8u_check_stage;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clr_cnt;
  logic [7:0] in_a, in_b;
  logic [8:0] in_o;

  logic        r1_ir, r1_ov, r1_err, r1_st;
  logic [8:0]  r1_sum, r1_fo;
  logic [7:0]  r1_fa, r1_fb;
  logic [15:0] r1_cnt;

  logic        r0_ir, r0_ov, r0_err, r0_st;
  logic [8:0]  r0_sum, r0_fo;
  logic [7:0]  r0_fa, r0_fb;
  logic [3:0]  r0_cnt;

  int vecs = 0;
  int errs = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  addr8u_check_stage #(.CORRECT(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r1_ir),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .out_valid(r1_ov), .out_ready(out_ready),
    .out_sum(r1_sum), .out_err(r1_err),
    .err_cnt(r1_cnt), .err_sticky(r1_st),
    .first_a(r1_fa), .first_b(r1_fb), .first_o(r1_fo),
    .clr_cnt(clr_cnt)
  );

  addr8u_check_stage #(.CORRECT(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r0_ir),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .out_valid(r0_ov), .out_ready(out_ready),
    .out_sum(r0_sum), .out_err(r0_err),
    .err_cnt(r0_cnt), .err_sticky(r0_st),
    .first_a(r0_fa), .first_b(r0_fb), .first_o(r0_fo),
    .clr_cnt(clr_cnt)
  );

  typedef struct {
    bit          v;
    bit [8:0]    sum;
    bit          err;
    int unsigned cnt;
    bit          st;
    bit [7:0]    fa;
    bit [7:0]    fb;
    bit [8:0]    fo;
  } mdl_t;

  mdl_t m1, m0;

  function automatic mdl_t nxt(mdl_t m, bit cor, int w);
    mdl_t r = m;
    int unsigned g, mx;
    bit acc, mis;
    mx = (32'd1 << w) - 1;
    if (rst) begin
      r = '{default: 0};
      return r;
    end
    acc = in_valid && (!m.v || out_ready);
    g = int'(in_a) + int'(in_b);
    mis = g != int'(in_o);
    if (clr_cnt) begin
      r.cnt = 0; r.st = 0;
      r.fa = 0; r.fb = 0; r.fo = 0;
    end
    if (acc && mis) begin
      if (r.cnt < mx) r.cnt++;
      if (!r.st) begin
        r.st = 1;
        r.fa = in_a; r.fb = in_b; r.fo = in_o;
      end
    end
    if (acc) begin
      r.v = 1;
      r.sum = (cor && mis) ? 9'(g) : in_o;
      r.err = mis;
    end else if (out_ready) begin
      r.v = 0;
    end
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input mdl_t m,
                     input logic ov, input logic [8:0] s,
                     input logic e, input logic [31:0] c,
                     input logic st, input logic [7:0] fa,
                     input logic [7:0] fb, input logic [8:0] fo,
                     input logic ir);
    chk({t, ".out_valid"}, 32'(ov), 32'(m.v));
    if (m.v) begin
      chk({t, ".out_sum"}, 32'(s), 32'(m.sum));
      chk({t, ".out_err"}, 32'(e), 32'(m.err));
    end
    chk({t, ".err_cnt"}, c, m.cnt);
    chk({t, ".err_sticky"}, 32'(st), 32'(m.st));
    chk({t, ".first_a"}, 32'(fa), 32'(m.fa));
    chk({t, ".first_b"}, 32'(fb), 32'(m.fb));
    chk({t, ".first_o"}, 32'(fo), 32'(m.fo));
    chk({t, ".in_ready"}, 32'(ir),
        32'(!m.v || out_ready));
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp("c1", m1, r1_ov, r1_sum, r1_err, 32'(r1_cnt),
          r1_st, r1_fa, r1_fb, r1_fo, r1_ir);
      cmp("c0", m0, r0_ov, r0_sum, r0_err, 32'(r0_cnt),
          r0_st, r0_fa, r0_fb, r0_fo, r0_ir);
    end
  end

  task automatic step();
    mdl_t n1, n0;
    n1 = nxt(m1, 1'b1, 16);
    n0 = nxt(m0, 1'b0, 4);
    @(posedge clk);
    m1 = n1;
    m0 = n0;
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] a,
                     input logic [7:0] b, input logic [8:0] o);
    in_valid = v; in_a = a; in_b = b; in_o = o;
  endtask

  initial begin
    m1 = '{default: 0};
    m0 = '{default: 0};
    rst = 1'b1; clr_cnt = 1'b0; out_ready = 1'b1;
    drv(1'b0, 8'h00, 8'h00, 9'h000);
    step(); step();
    rst = 1'b0;
    run = 1'b1;
    chk("rst.out_valid", 32'(r1_ov), 0);
    chk("rst.err_cnt", 32'(r1_cnt), 0);
    chk("rst.in_ready", 32'(r1_ir), 1);

    // carry-out, correct result
    drv(1'b1, 8'hFF, 8'h01, 9'h100);
    step();
    chk("carry.sum", 32'(r1_sum), 32'h100);
    chk("carry.err", 32'(r1_err), 0);
    chk("carry.cnt", 32'(r1_cnt), 0);

    // bit 0 flipped
    drv(1'b1, 8'h12, 8'h34, 9'h047);
    step();
    chk("flip.sum_c1", 32'(r1_sum), 32'h046);
    chk("flip.sum_c0", 32'(r0_sum), 32'h047);
    chk("flip.err", 32'(r1_err), 1);
    chk("flip.cnt", 32'(r1_cnt), 1);
    chk("flip.sticky", 32'(r1_st), 1);
    chk("flip.first_a", 32'(r1_fa), 32'h12);
    chk("flip.first_b", 32'(r1_fb), 32'h34);
    chk("flip.first_o", 32'(r1_fo), 32'h047);

    // backpressure
    drv(1'b1, 8'h50, 8'h5A, 9'h0AA);
    step();
    out_ready = 1'b0;
    drv(1'b1, 8'h01, 8'h01, 9'h002);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.sum", 32'(r1_sum), 32'h0AA);
      chk("bp.in_ready", 32'(r1_ir), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp.release", 32'(r1_sum), 32'h002);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 8'(i * 16 + 3), 8'(i + 7),
          9'(i * 17 + 10));
      step();
      chk("b2b.sum", 32'(r1_sum), 32'(i * 17 + 10));
    end

    // second mismatch keeps the first capture
    drv(1'b1, 8'h80, 8'h80, 9'h000);
    step();
    chk("mis2.cnt", 32'(r1_cnt), 2);
    chk("mis2.first_a", 32'(r1_fa), 32'h12);
    chk("mis2.sum_c1", 32'(r1_sum), 32'h100);

    // clear and mismatch in one cycle
    clr_cnt = 1'b1;
    drv(1'b1, 8'h03, 8'h04, 9'h000);
    step();
    clr_cnt = 1'b0;
    chk("clr.cnt", 32'(r1_cnt), 1);
    chk("clr.first_a", 32'(r1_fa), 32'h03);
    chk("clr.first_o", 32'(r1_fo), 32'h000);

    // idle mismatching inputs are ignored
    drv(1'b0, 8'h01, 8'h02, 9'h000);
    step(); step();
    chk("idle.cnt", 32'(r1_cnt), 1);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 8'(i), 8'h10, 9'h1FF);
      step();
    end
    chk("sat.cnt_c0", 32'(r0_cnt), 32'hF);
    chk("sat.cnt_c1", 32'(r1_cnt), 21);

    // reset while holding a result
    out_ready = 1'b0;
    drv(1'b0, 8'h00, 8'h00, 9'h000);
    step();
    chk("hold.valid", 32'(r1_ov), 1);
    rst = 1'b1;
    step();
    chk("rst2.valid", 32'(r1_ov), 0);
    chk("rst2.sum", 32'(r1_sum), 0);
    chk("rst2.err", 32'(r1_err), 0);
    chk("rst2.cnt_c0", 32'(r0_cnt), 0);
    chk("rst2.sticky", 32'(r1_st), 0);
    chk("rst2.first_a", 32'(r1_fa), 0);
    chk("rst2.in_ready", 32'(r1_ir), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    step(); step();
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/addr8u_check_stage.md
ADDR8U_CHECK_STAGE -- requirements
Module: addr8u_check_stage

Interface
REQ-001 The block SHALL have parameter CORRECT, default 0, meaning 0 = forward adder sum unchanged, 1 = forward golden sum on mismatch.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the mismatch counter (legal 4..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream transaction present.
REQ-006 in_ready  output  1  block can accept a transaction this cycle.
REQ-007 in_a  input  8  operand A[7:0], as driven to the combinational unsigned 8-bit adder.
REQ-008 in_b  input  8  operand B[7:0], as driven to the adder.
REQ-009 in_o  input  9  adder result O[8:0] for in_a/in_b, same cycle.
REQ-010 out_valid  output  1  registered result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_sum  output  9  registered sum.
REQ-013 out_err  output  1  registered result was a mismatch.
REQ-014 err_cnt  output  CNT_W  saturating count of accepted mismatches.
REQ-015 err_sticky  output  1  at least one mismatch since last reset/clear.
REQ-016 first_a, first_b  output  8 each  operands of first mismatch; first_o  output  9  adder result of first mismatch.
REQ-017 clr_cnt  input  1  synchronous clear of err_cnt, err_sticky, first_* capture.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-019 Golden sum SHALL be the 9-bit zero-extended in_a + in_b; mismatch SHALL be golden != in_o across all 9 bits.
REQ-020 Latency SHALL be 1 cycle: accepted data appears on out_sum/out_err with out_valid=1 the next cycle.
REQ-021 out_sum SHALL be in_o when CORRECT=0, and golden sum when CORRECT=1 and mismatch; out_err SHALL reflect mismatch regardless of CORRECT.
REQ-022 Output slot SHALL be a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL with new data on out_ready and accept in the same cycle.
REQ-023 While FULL and out_ready=0, out_sum/out_err SHALL hold stable and in_ready SHALL be 0.
REQ-024 Inputs presented with in_valid=0 or when not accepted SHALL not affect any state, including counters.
REQ-025 err_cnt SHALL increment by 1 per accepted mismatch and saturate at 2^CNT_W-1 (no wrap).
REQ-026 Capture FSM SHALL have states CLEAN and FAULTED: CLEAN->FAULTED on first accepted mismatch, latching first_a/first_b/first_o and setting err_sticky; in FAULTED, first_* SHALL not change on further mismatches.
REQ-027 clr_cnt=1 SHALL return err_cnt to 0, err_sticky to 0, first_* to 0, FSM to CLEAN; the output slot and handshake SHALL be unaffected.
REQ-028 clr_cnt and an accepted mismatch in the same cycle: clear first, then count; result err_cnt=1, FAULTED, first_* = that transaction.
REQ-029 Block SHALL be fully synchronous with no combinational path from in_a/in_b/in_o to any output.

Reset
REQ-030 rst=1 at a clock edge SHALL set out_valid=0, out_sum=0, out_err=0, err_cnt=0, err_sticky=0, first_a=first_b=0, first_o=0, FSM to CLEAN; rst SHALL have priority over clr_cnt and accept.
REQ-031 During rst, in_ready SHALL follow REQ-018 from the reset state; reset mid-transaction SHALL discard the held result with no completion.

Verification
REQ-032 a=0xFF, b=0x01, o=0x100, out_ready=1 -> next cycle out_valid=1, out_sum=0x100, out_err=0, err_cnt=0.
REQ-033 a=0x12, b=0x34, o=0x047 (bit 0 flipped), CORRECT=1 -> out_sum=0x046, out_err=1, err_cnt=1, err_sticky=1, first_a=0x12, first_b=0x34, first_o=0x047; repeat with CORRECT=0 -> out_sum=0x047.
REQ-034 Backpressure: out_ready=0 for 3 cycles after result 0x0AA -> in_ready=0, out_sum held 0x0AA; out_ready=1 with in_valid=1 same cycle -> back-to-back throughput 1 result/cycle, no loss or duplication.
REQ-035 Second mismatch a=0x80, b=0x80, o=0x000 after REQ-033 -> err_cnt=2, first_* unchanged; then clr_cnt with accepted mismatch same cycle -> err_cnt=1, first_a=that operand.
REQ-036 CNT_W=4, 20 accepted mismatches -> err_cnt saturates at 0xF; rst asserted while out_valid=1 -> next cycle all outputs at reset values.
